// File: rtl/song_pkg.sv
// Shared types and constants for the song record/playback path.
package song_pkg;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_NOTE_W = 10;

  // Bit that marks a RAM word as a real note slot (vs. the end marker).
  localparam int unsigned VALID_BIT = DEF_DATA_W - 1;

  localparam logic [DEF_DATA_W-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StRecord,
    StFinish,
    StDone
  } rec_state_e;

  // Pack a note vector into a RAM word: {valid, zero pad, notes}.
  function automatic logic [DEF_DATA_W-1:0] pack_word(input logic                  valid,
                                                      input logic [DEF_NOTE_W-1:0] notes);
    logic [DEF_DATA_W-1:0] word;
    word                   = '0;
    word[VALID_BIT]        = valid;
    word[DEF_NOTE_W-1:0]   = notes;
    return word;
  endfunction

endpackage

// File: rtl/note_accumulator.sv
// OR-accumulating note register: catches keys pressed briefly between beats.
module note_accumulator #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,   // acc <= din (highest priority)
  input  logic         clear,  // acc <= 0
  input  logic         accum,  // acc <= acc | din
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q, acc_d;

  // Next-state selection; load beats clear beats accumulate.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = din;
    end else if (clear) begin
      acc_d = '0;
    end else if (accum) begin
      acc_d = acc_q | din;
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/note_recorder.sv
// Record-mode stage: writes one note word per beat into the song RAM and
// terminates the song with an end marker when recording stops.
module note_recorder
  import song_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NOTE_W = DEF_NOTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              beat,
  input  logic [NOTE_W-1:0] notes_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W:0]   rec_length,
  output logic              recording,
  output logic              full,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
  localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

  rec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d, len_inc;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              recording_q, done_q;

  logic              acc_load, acc_clear, acc_accum;
  logic [NOTE_W-1:0] acc, merged;

  note_accumulator #(
    .W (NOTE_W)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .load  (acc_load),
    .clear (acc_clear),
    .accum (acc_accum),
    .din   (notes_in),
    .acc   (acc)
  );

  // Word written on a beat includes notes live in the beat cycle itself.
  assign merged  = acc | notes_in;
  assign len_inc = len_q + 1'b1;

  // Next-state, pointer and RAM-write decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    full_d    = full_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    acc_load  = 1'b0;
    acc_clear = 1'b0;
    acc_accum = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StArmed;
          ptr_d     = '0;
          len_d     = '0;
          full_d    = 1'b0;
          acc_clear = 1'b1;
        end
      end

      StArmed: begin
        if (stop) begin
          state_d = StFinish;
        end else if (beat) begin
          // Alignment beat: no write, start the first interval from notes_in.
          state_d  = StRecord;
          acc_load = 1'b1;
        end
      end

      StRecord: begin
        if (beat) begin
          wren_d    = 1'b1;
          addr_d    = ptr_q;
          data_d    = pack_word(1'b1, merged);
          acc_clear = 1'b1;
          len_d     = len_inc;
          if (ptr_q != PTR_MAX) begin
            ptr_d = ptr_q + 1'b1;
          end
          // A filling write wins over a simultaneous stop: no marker fits.
          if (len_inc == LEN_FULL) begin
            full_d  = 1'b1;
            state_d = StDone;
          end else if (stop) begin
            state_d = StFinish;
          end
        end else begin
          acc_accum = 1'b1;
          if (stop) begin
            state_d = StFinish;
          end
        end
      end

      StFinish: begin
        wren_d  = 1'b1;
        addr_d  = ptr_q;
        data_d  = END_MARKER;
        state_d = StDone;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      len_q       <= '0;
      full_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      recording_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      full_q      <= full_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      recording_q <= (state_d == StArmed) || (state_d == StRecord);
      done_q      <= (state_d == StDone);
    end
  end

  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign ram_wren   = wren_q;
  assign rec_length = len_q;
  assign recording  = recording_q;
  assign full       = full_q;
  assign done       = done_q;

endmodule

// File: tb/tb_note_recorder.sv
// Self-checking bench for note_recorder: RAM writes are scoreboarded.
module tb_note_recorder;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NOTE_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              beat = 1'b0;
  logic [NOTE_W-1:0] notes_in = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [ADDR_W:0]   rec_length;
  logic              recording;
  logic              full;
  logic              done;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  note_recorder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NOTE_W (NOTE_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .beat       (beat),
    .notes_in   (notes_in),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .rec_length (rec_length),
    .recording  (recording),
    .full       (full),
    .done       (done)
  );

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      wr_t exp;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 ram_addr, ram_data);
      end else begin
        exp = exp_q.pop_front();
        if ({ram_addr, ram_data} !== exp) begin
          fails++;
          $display("FAIL ram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   ram_addr, ram_data, exp.addr, exp.data);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Start plus the alignment beat (no write).
  task automatic arm();
    pulse_start();
    tick();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  // Hold v for a while, then beat while still holding it.
  task automatic beat_word(input logic [ADDR_W-1:0] a, input logic [NOTE_W-1:0] v);
    notes_in = v;
    tick(2);
    expect_write(a, {1'b1, {(DATA_W-NOTE_W-1){1'b0}}, v});
    beat = 1'b1;
    tick();
    beat     = 1'b0;
    notes_in = '0;
  endtask

  task automatic check_drained(input string name);
    tick(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained: %0d writes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    tests++;
    if ({ram_wren, ram_addr, ram_data, rec_length, recording, full, done} !== '0) begin
      fails++;
      $display("FAIL reset_values: wren=%b addr=%0d data=%h len=%0d rec=%b full=%b done=%b, required all 0",
               ram_wren, ram_addr, ram_data, rec_length, recording, full, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    arm();
    tests++;
    if (recording !== 1'b1) begin
      fails++;
      $display("FAIL basic_recording: got %b, required 1", recording);
    end
    beat_word(0, 10'h001);
    beat_word(1, 10'h002);
    beat_word(2, 10'h004);
    tick();
    expect_write(3, 32'h0000_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(2);
    tests++;
    if (rec_length !== 7'd3 || done !== 1'b1 || recording !== 1'b0) begin
      fails++;
      $display("FAIL basic_status: len=%0d done=%b rec=%b, required len=3 done=1 rec=0",
               rec_length, done, recording);
    end
    check_drained("basic");
  endtask

  task automatic test_glitch();
    arm();
    tick(2);
    notes_in = 10'h010;
    tick();
    notes_in = 10'h000;
    tick(3);
    expect_write(0, 32'h8000_0010);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    expect_write(1, 32'h0000_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_drained("glitch");
  endtask

  task automatic test_full();
    arm();
    for (int i = 0; i < 64; i++) begin
      beat_word(i[ADDR_W-1:0], 10'h3FF);
    end
    tick();
    tests++;
    if (full !== 1'b1 || rec_length !== 7'd64 || done !== 1'b1) begin
      fails++;
      $display("FAIL full_status: full=%b len=%0d done=%b, required full=1 len=64 done=1",
               full, rec_length, done);
    end
    // Extra beat and stop after full: no writes expected.
    notes_in = 10'h3FF;
    beat     = 1'b1;
    tick();
    beat = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    notes_in = '0;
    check_drained("full");
    tests++;
    if (rec_length !== 7'd64 || full !== 1'b1) begin
      fails++;
      $display("FAIL full_hold: len=%0d full=%b, required len=64 full=1", rec_length, full);
    end
  endtask

  task automatic test_stop_beat();
    arm();
    tests++;
    if (full !== 1'b0 || rec_length !== 7'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL restart_clear: full=%b len=%0d done=%b, required 0 0 0",
               full, rec_length, done);
    end
    beat_word(0, 10'h005);
    beat_word(1, 10'h00A);
    notes_in = 10'h3C0;
    tick(2);
    expect_write(2, 32'h8000_03C0);
    expect_write(3, 32'h0000_0000);
    beat = 1'b1;
    stop = 1'b1;
    tick();
    beat     = 1'b0;
    stop     = 1'b0;
    notes_in = '0;
    tick(2);
    tests++;
    if (rec_length !== 7'd3 || done !== 1'b1) begin
      fails++;
      $display("FAIL stop_beat_status: len=%0d done=%b, required len=3 done=1",
               rec_length, done);
    end
    check_drained("stop_beat");
  endtask

  task automatic test_armed_stop();
    pulse_start();
    tick(2);
    expect_write(0, 32'h0000_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(2);
    tests++;
    if (rec_length !== 7'd0 || done !== 1'b1 || recording !== 1'b0) begin
      fails++;
      $display("FAIL armed_stop_status: len=%0d done=%b rec=%b, required len=0 done=1 rec=0",
               rec_length, done, recording);
    end
    check_drained("armed_stop");
  endtask

  task automatic test_reset_mid();
    arm();
    for (int i = 0; i < 5; i++) begin
      beat_word(i[ADDR_W-1:0], 10'(i + 1));
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (ram_wren !== 1'b0 || recording !== 1'b0 || rec_length !== 7'd0) begin
      fails++;
      $display("FAIL reset_mid: wren=%b rec=%b len=%0d, required 0 0 0",
               ram_wren, recording, rec_length);
    end
    // Beats while idle must not write.
    notes_in = 10'h155;
    for (int i = 0; i < 3; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      tick(2);
    end
    notes_in = '0;
    check_drained("reset_idle");
    // Recovery restarts at address 0.
    arm();
    beat_word(0, 10'h200);
    expect_write(1, 32'h0000_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(2);
    tests++;
    if (rec_length !== 7'd1 || done !== 1'b1) begin
      fails++;
      $display("FAIL reset_recover: len=%0d done=%b, required len=1 done=1", rec_length, done);
    end
    check_drained("reset_recover");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_full();
    test_stop_beat();
    test_armed_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Record-mode stage placed directly downstream of the control FSM and the beat clock divider.
- Samples the note switches on every beat tick while recording and writes one note word per beat into the 64-word x 32-bit song RAM.
- Writes an end-of-song marker when recording stops, so the playback stage knows where the song ends.
- Reports the recorded length, a busy flag and a full flag to the control FSM and the LEDs.

Parameters:
- ADDR_W, 6: RAM address width; depth = 2**ADDR_W = 64 words.
- DATA_W, 32: RAM word width.
- NOTE_W, 10: note vector width, one bit per switch; NOTE_W <= DATA_W-1.

Ports:
- clk  in  1  system clock, CLOCK_50 domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from control: arm recording.
- stop  in  1  one-cycle pulse from control: end recording.
- beat  in  1  one-cycle tick from the clock divider, one per note slot.
- notes_in  in  NOTE_W  live note switches.
- ram_addr  out  ADDR_W  RAM write address.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable, one-cycle pulse per word.
- rec_length  out  ADDR_W+1  count of note words written, 0..64; excludes the marker.
- recording  out  1  high in ARMED and RECORD.
- full  out  1  high once 64 note words have been written.
- done  out  1  high in DONE.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: state IDLE, write pointer 0, accumulator 0, ram_addr 0, ram_data 0, ram_wren 0, rec_length 0, recording 0, full 0, done 0.
- Reset mid-operation: any in-flight write is dropped, and ram_wren is 0 from the first edge that samples reset high.
- States:
  - IDLE: start -> ARMED. Clears write pointer, rec_length, full and accumulator.
  - ARMED: waits for the first beat so recording is beat-aligned. beat -> RECORD, with no write on this beat; the accumulator is cleared and loaded with notes_in. stop -> FINISH. start is ignored.
  - RECORD: every cycle the accumulator is ORed with notes_in, so a key pressed briefly between beats is kept.
    - On beat: register ram_wren=1, ram_addr=pointer, ram_data={1'b1 valid, zeros, acc|notes_in}.
    - Then increment the pointer and rec_length, and reload the accumulator with 0.
    - After the 64th write (rec_length==64): set full and go to DONE with no marker.
    - stop without beat -> FINISH.
    - stop and beat in the same cycle: the beat write happens first, then FINISH (or DONE if that write filled the RAM).
    - start is ignored.
  - FINISH: for exactly one cycle, registered ram_wren=1, ram_addr=pointer, ram_data=all zeros (end marker). rec_length is unchanged. Goes to DONE next cycle.
  - DONE: done=1. start -> ARMED with the IDLE clearing actions applied. stop and beat are ignored.
- Latency: the write appears on ram_* the cycle after the beat is sampled. ram_wren is never high for two consecutive cycles except for a beat write immediately followed by the FINISH marker write.
- Width and wrap rules:
  - The pointer never wraps. It saturates at 63, and writes stop once full.
  - rec_length is ADDR_W+1 bits so that 64 is representable.
- ram_addr and ram_data hold their last values when ram_wren=0.

Decomposition:
- Shared package (song_pkg):
  - recorder state encoding.
  - ADDR_W/DATA_W/NOTE_W defaults.
  - VALID_BIT index (DATA_W-1).
  - END_MARKER constant (all zeros).
  - Word-packing function {valid, pad, notes}.
- Sub-module: note_accumulator. Holds the OR-accumulate register with load/clear inputs and is reusable by a future live-monitor mode. The FSM and pointer logic stay in note_recorder.

Test Plan:
- Reset, then start, beat, then 3 beats with notes_in=10'h001, 10'h002, 10'h004, then stop. Required:
  - ram writes addr0=32'h8000_0001, addr1=32'h8000_0002, addr2=32'h8000_0004, addr3=32'h0000_0000.
  - rec_length=3, done=1.
- In RECORD, pulse notes_in=10'h010 for one cycle mid-interval, then 10'h000 until beat -> word written = 32'h8000_0010.
- start, first beat, then 64 further beats with notes_in=10'h3FF. Required:
  - 64 writes, addresses 0..63.
  - full=1, rec_length=64, done=1.
  - no marker write, and no write on a 65th beat.
- stop and beat asserted in the same cycle after 2 words -> word at addr2 written, then marker at addr3 on the next cycle, rec_length=3.
- start, then stop while ARMED -> single marker write at addr0, rec_length=0, done=1.
- Assert reset for one cycle in the RECORD state after 5 words -> next cycle ram_wren=0, recording=0, rec_length=0. Subsequent beats cause no writes until start.
